// File: rtl/adder_subtractor_4bit.sv
// adder_subtractor_4bit: registered ripple-carry adder/subtractor with valid handshake
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   a, b      unsigned operands
//   cin       0 = add, 1 = subtract (also the stage-0 carry-in)
//   in_valid  capture a/b/cin this cycle
//   s, c0     registered result and carry-out / not-borrow
//   out_valid s/c0 hold a new result this cycle
//   ovf       signed overflow, present only when ADDSUB_OVF_EN is defined
module adder_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c0,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bx, sum, s_q, s_d;
  logic             c0_q, c0_d, v_q, v_d;
  assign bx   = b ^ {WIDTH{cin}};
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  always_comb begin
    s_d  = in_valid ? sum : s_q;
    c0_d = in_valid ? c[WIDTH] : c0_q;
    v_d  = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      c0_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      s_q  <= s_d;
      c0_q <= c0_d;
      v_q  <= v_d;
    end
  end
  assign s         = s_q;
  assign c0        = c0_q;
  assign out_valid = v_q;
`ifdef ADDSUB_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  logic ovf_q, ovf_d;
  always_comb ovf_d = in_valid ? (c[WIDTH-1] ^ c[WIDTH]) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_adder_subtractor_4bit.sv
// tb_adder_subtractor_4bit: table-driven check of the adder/subtractor
module tb_adder_subtractor_4bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b, s;
  logic       cin, in_valid, c0, out_valid, ovf;
  int         pass_cnt = 0, total = 0;
  typedef struct {
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] s;
    logic       c0, ovf;
  } vec_t;
  vec_t vecs[12];
  always #5 clk = ~clk;
  adder_subtractor_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .s(s), .c0(c0),
`ifdef ADDSUB_OVF_EN
    .ovf(ovf),
`endif
    .out_valid(out_valid)
  );
`ifndef ADDSUB_OVF_EN
  assign ovf = 1'b0;
`endif
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%b required=%b", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic drive(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input logic vi);
    @(negedge clk);
    a = ai; b = bi; cin = ci; in_valid = vi;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0]  = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0};
    vecs[1]  = '{4'b1001, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{4'b1010, 4'b0101, 1'b1, 4'b0101, 1'b1, 1'b1};
    vecs[5]  = '{4'b1001, 4'b0111, 1'b1, 4'b0010, 1'b1, 1'b1};
    vecs[6]  = '{4'b0110, 4'b0001, 1'b1, 4'b0101, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[8]  = '{4'b0001, 4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1};
    vecs[10] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[11] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    rst_n = 1'b0; a = 4'b1010; b = 4'b0101; cin = 1'b0; in_valid = 1'b1;
    #1;
    chk("rst_s", s, 4'b0000);
    chk("rst_c0", {3'b0, c0}, 4'b0000);
    chk("rst_valid", {3'b0, out_valid}, 4'b0000);
    @(posedge clk);
    #1;
    chk("rst_edge_valid", {3'b0, out_valid}, 4'b0000);
    chk("rst_edge_s", s, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", {3'b0, out_valid}, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      chk($sformatf("v%0d_s", i), s, vecs[i].s);
      chk($sformatf("v%0d_c0", i), {3'b0, c0}, {3'b0, vecs[i].c0});
      chk($sformatf("v%0d_valid", i), {3'b0, out_valid}, 4'b0001);
`ifdef ADDSUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), {3'b0, ovf}, {3'b0, vecs[i].ovf});
`endif
    end
    drive(4'b1010, 4'b0101, 1'b0, 1'b1);
    chk("load_s", s, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 4'b0110, 1'b1, 1'b0);
      chk($sformatf("hold%0d_s", i), s, 4'b1111);
      chk($sformatf("hold%0d_c0", i), {3'b0, c0}, 4'b0000);
      chk($sformatf("hold%0d_valid", i), {3'b0, out_valid}, 4'b0000);
    end
    drive(4'b1010, 4'b0101, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s", s, 4'b0000);
    chk("async_rst_c0", {3'b0, c0}, 4'b0000);
    chk("async_rst_valid", {3'b0, out_valid}, 4'b0000);
    drive(4'b1001, 4'b0111, 1'b0, 1'b1);
    chk("rst_discard_valid", {3'b0, out_valid}, 4'b0000);
    chk("rst_discard_s", s, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    drive(4'b0110, 4'b0001, 1'b0, 1'b1);
    chk("post_rst_s", s, 4'b0111);
    chk("post_rst_valid", {3'b0, out_valid}, 4'b0001);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/adder_subtractor_4bit.md
ADDER_SUBTRACTOR_4BIT -- requirements
Module: adder_subtractor_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; all verification uses 4.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: a  input  WIDTH  operand A, unsigned.
REQ-005 Port: b  input  WIDTH  operand B, unsigned.
REQ-006 Port: cin  input  1  mode select: 0 = add (a+b), 1 = subtract (a-b).
REQ-007 Port: in_valid  input  1  a, b and cin are captured on this cycle.
REQ-008 Port: s  output  WIDTH  registered sum/difference.
REQ-009 Port: c0  output  1  registered carry-out (add) or not-borrow (subtract).
REQ-010 Port: out_valid  output  1  s/c0 (and ovf) hold a new result this cycle.

Function
REQ-011 Datapath SHALL be a WIDTH-stage ripple-carry chain of full adders; operand B is XORed bitwise with cin, and cin is the stage-0 carry-in.
REQ-012 Add (cin=0): {c0,s} = a + b, modulo 2^(WIDTH+1).
REQ-013 Subtract (cin=1): {c0,s} = a + ~b + 1; s = (a-b) mod 2^WIDTH; c0=1 when a>=b (no borrow), c0=0 when a<b.
REQ-014 Latency: when in_valid=1 at a rising edge, s, c0 and out_valid=1 SHALL update at that edge (one-cycle latency, registered outputs).
REQ-015 When in_valid=0 at a rising edge, s and c0 SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 Back-to-back in_valid=1 cycles SHALL each produce one result; throughput is one operation per clock.
REQ-017 Wrap-around: add overflow beyond WIDTH bits appears only in c0; s SHALL truncate (e.g. 1001+0111 -> s=0000, c0=1).
REQ-018 cin changing between cycles SHALL affect only operations captured with that cin value; no mode state is retained.

Reset
REQ-019 rst_n=0 SHALL immediately (asynchronously) force s=0, c0=0, out_valid=0 (and ovf=0 when present).
REQ-020 Reset deassertion is synchronized by the user; the first result after reset comes from the first in_valid=1 edge with rst_n=1.
REQ-021 Reset asserted in the same cycle as in_valid=1 SHALL discard that operation.

Configuration
REQ-022 Macro ADDSUB_OVF_EN: when defined, output port ovf (1 bit, registered, same timing as s) SHALL be present and equal to the carry into the MSB stage XOR c0 (two's-complement signed overflow).
REQ-023 Without ADDSUB_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 Add: cin=0, a=1010, b=0101, in_valid=1 -> next edge s=1111, c0=0, out_valid=1.
REQ-025 Add wrap: cin=0, a=1001, b=0111 -> s=0000, c0=1; a=0110, b=0001 -> s=0111, c0=0; a=0000, b=0000 -> s=0000, c0=0.
REQ-026 Subtract: cin=1, a=1010, b=0101 -> s=0101, c0=1; a=1001, b=0111 -> s=0010, c0=1; a=0110, b=0001 -> s=0101, c0=1; a=0000, b=0000 -> s=0000, c0=1.
REQ-027 Borrow: cin=1, a=0001, b=0010 -> s=1111, c0=0; with ADDSUB_OVF_EN, a=0111, b=1000 subtract -> s=1111, ovf=1.
REQ-028 Hold/valid: result 1111 loaded, then in_valid=0 for 3 cycles -> s stays 1111, out_valid=0.
REQ-029 Reset: pull rst_n low mid-clock-period with s=1111 -> s=0000, c0=0, out_valid=0 before the next edge; an in_valid=1 edge during reset yields no result.
